seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an 8-digit seven-segment display; sits directly upstream of the 3-to-8 digit decoder.
- Holds eight 4-bit hex digits plus a per-digit blank flag.
- Steps a 3-bit digit index at a programmable dwell rate; that index drives the decoder select input.
- Outputs, in the same cycle, the segment pattern of the digit that index selects.

---
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// It holds eight hex digits, each with a blank flag. It steps a 3-bit digit
// index every DIV clocks, and that index drives the downstream 3-to-8 digit
// decoder. It also registers the segment pattern for the selected digit, so
// that pattern and sel always change on the same edge.
//
// State table:
//   state | meaning
//   HOLD  | en=0: prescaler parked at 0, sel frozen, segments dark
//   SCAN  | en=1: prescaler counts, sel advances every DIV cycles
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   en          in   scan enable (selects SCAN/HOLD each cycle)
//   wr_en       in   digit register write strobe
//   wr_addr[2:0] in  digit index to write
//   wr_data[4:0] in  {blank, hex[3:0]}
//   sel[2:0]    out  current digit index (decoder select)
//   seg[6:0]    out  active-high {g,f,e,d,c,b,a} for the digit at sel
//   frame_done  out  one-cycle pulse on the cycle sel first reads 0 after 7
module seg_scan_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [2:0] sel,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  typedef enum logic {
    HOLD = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] pre_cur;
  logic        dwell_end;
  logic [2:0]  sel_q, sel_d;
  logic [6:0]  seg_q, seg_d;
  logic        frame_done_q, frame_done_d;
  logic [4:0]  digit_q [8];
  logic [4:0]  digit_d [8];

  function automatic logic [6:0] hex_enc(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // State register, together with all datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HOLD;
      pre_q        <= '0;
      sel_q        <= '0;
      seg_q        <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= 5'h10;
      end
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= digit_d[i];
      end
    end
  end

  // Next-state logic: the mode follows en every cycle. Coming out of HOLD,
  // the dwell restarts from zero, so the held digit gets a full DIV period.
  always_comb begin
    state_d   = en ? SCAN : HOLD;
    pre_cur   = (state_q == SCAN) ? pre_q : '0;
    dwell_end = (pre_cur == DIV_M1);
    pre_d     = '0;
    sel_d     = sel_q;
    if (state_d == SCAN) begin
      if (dwell_end) begin
        pre_d = '0;
        sel_d = sel_q + 3'd1;
      end else begin
        pre_d = pre_cur + 16'd1;
      end
    end
    for (int i = 0; i < 8; i++) begin
      digit_d[i] = digit_q[i];
    end
    if (wr_en) begin
      digit_d[wr_addr] = wr_data;
    end
  end

  // Output logic. The pattern is looked up with the sel value this edge
  // produces, so seg and sel always agree. It reads the pre-write digit
  // contents, so a write shows up one edge after it lands.
  always_comb begin
    seg_d        = '0;
    frame_done_d = 1'b0;
    if (state_d == SCAN) begin
      frame_done_d = dwell_end && (sel_q == 3'd7);
      if (!digit_q[sel_d][4]) begin
        seg_d = hex_enc(digit_q[sel_d][3:0]);
      end
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl. Two instances share one set of inputs:
// u_dut4 uses DIV=4 and u_dut1 uses DIV=1. A behavioural model predicts
// each edge's outputs when the stimulus is driven. Those predictions are
// queued, then popped and compared once the edge has happened.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [2:0] sel4, sel1;
  logic [6:0] seg4, seg1;
  logic       fd4, fd1;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sel(sel4), .seg(seg4), .frame_done(fd4)
  );

  seg_scan_ctrl #(.DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sel(sel1), .seg(seg1), .frame_done(fd1)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t       q4[$];
  exp_t       q1[$];
  logic [6:0] enc_tab [16];
  logic [3:0] vals [8];
  logic [4:0] m_dig [8];
  int         m_sel [2];
  int         m_pre [2];
  int         m_div [2];
  int         fd_cnt [2];
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic e, input logic we,
                      input logic [2:0] wa, input logic [4:0] wd);
    exp_t x;
    rst_n = r; en = e; wr_en = we; wr_addr = wa; wr_data = wd;
    for (int k = 0; k < 2; k++) begin
      x.fd = 1'b0;
      if (!r) begin
        m_sel[k] = 0;
        m_pre[k] = 0;
        x.seg = '0;
      end else if (e) begin
        if (m_pre[k] == m_div[k] - 1) begin
          m_pre[k] = 0;
          if (m_sel[k] == 7) x.fd = 1'b1;
          m_sel[k] = (m_sel[k] + 1) % 8;
        end else begin
          m_pre[k] = m_pre[k] + 1;
        end
        x.seg = m_dig[m_sel[k]][4] ? 7'h00 : enc_tab[m_dig[m_sel[k]][3:0]];
      end else begin
        m_pre[k] = 0;
        x.seg = '0;
      end
      x.sel = m_sel[k][2:0];
      if (k == 0) q4.push_back(x);
      else q1.push_back(x);
    end
    if (!r) begin
      for (int i = 0; i < 8; i++) m_dig[i] = 5'h10;
    end else if (we) begin
      m_dig[wa] = wd;
    end
    @(posedge clk);
    #1;
    x = q4.pop_front();
    check("sel4", 32'(sel4), 32'(x.sel));
    check("seg4", 32'(seg4), 32'(x.seg));
    check("fd4", 32'(fd4), 32'(x.fd));
    fd_cnt[0] += int'(fd4);
    x = q1.pop_front();
    check("sel1", 32'(sel1), 32'(x.sel));
    check("seg1", 32'(seg1), 32'(x.seg));
    check("fd1", 32'(fd1), 32'(x.fd));
    fd_cnt[1] += int'(fd1);
  endtask

  initial begin
    int n;
    int nz;
    enc_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vals    = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hE, 4'hF};
    m_div   = '{4, 1};
    m_sel   = '{0, 0};
    m_pre   = '{0, 0};
    fd_cnt  = '{0, 0};
    for (int i = 0; i < 8; i++) m_dig[i] = 5'h10;
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    check("rst_sel", 32'(sel4), 32'd0);
    check("rst_seg", 32'(seg4), 32'd0);
    check("rst_fd", 32'(fd4), 32'd0);

    // Blank scan: frame pulses counted over 64 enabled cycles.
    fd_cnt = '{0, 0};
    repeat (64) step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    check("frames_div4", 32'(fd_cnt[0]), 32'd2);
    check("frames_div1", 32'(fd_cnt[1]), 32'd8);

    // Load digits in HOLD, then scan a full frame.
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, i[2:0], {1'b0, vals[i]});
    step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    check("first_seg", 32'(seg4), 32'h06);
    repeat (31) step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);

    // All 16 hex values written while scanning.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, i[2:0], {1'b0, i[3:0]});
    repeat (8) step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, i[2:0], {1'b0, vals[i]});

    // HOLD in the middle of digit 5's dwell.
    n = 0;
    while (!(m_sel[0] == 5 && m_pre[0] == 1) && n < 100) begin
      step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      n++;
    end
    check("reach_sel5", 32'(n < 100), 32'd1);
    repeat (10) step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0);
    check("hold_sel", 32'(sel4), 32'd5);
    check("hold_seg", 32'(seg4), 32'd0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    check("resume_sel5", 32'(sel4), 32'd5);
    check("resume_seg5", 32'(seg4), 32'h7C);
    step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    check("resume_sel6", 32'(sel4), 32'd6);

    // Write digit 3 on the same edge that selects it, then blank it.
    n = 0;
    while (!(m_sel[0] == 2 && m_pre[0] == 3) && n < 100) begin
      step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      n++;
    end
    check("reach_sel2", 32'(n < 100), 32'd1);
    step(1'b1, 1'b1, 1'b1, 3'd3, 5'h08);
    check("wr_edge_sel", 32'(sel4), 32'd3);
    check("wr_edge_old", 32'(seg4), 32'h66);
    step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    check("wr_08", 32'(seg4), 32'h7F);
    step(1'b1, 1'b1, 1'b1, 3'd3, 5'h18);
    check("wr_18_pre", 32'(seg4), 32'h7F);
    step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    check("wr_18", 32'(seg4), 32'h00);

    // Reset at sel=6 together with a write: write dropped, all blank.
    n = 0;
    while (m_sel[0] != 6 && n < 100) begin
      step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      n++;
    end
    check("reach_sel6", 32'(n < 100), 32'd1);
    step(1'b0, 1'b1, 1'b1, 3'd6, 5'h05);
    check("mid_rst_sel", 32'(sel4), 32'd0);
    check("mid_rst_seg", 32'(seg4), 32'd0);
    check("mid_rst_fd", 32'(fd4), 32'd0);
    fd_cnt = '{0, 0};
    nz = 0;
    repeat (32) begin
      step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      if (seg4 != 7'h00 || seg1 != 7'h00) nz++;
    end
    check("all_blank", 32'(nz), 32'd0);
    check("frame_after_rst", 32'(fd_cnt[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
